row_token_readout: RTL and testbench
====================================

// Module: row_token_readout
// PURPOSE
//  Core-column readout sequencer feeding the row address decoder. It snapshots the
//  per-row HitPending flags when Start is seen, then passes a one-hot token through
//  the set rows, lowest index first, and reads each row once.
//  Each hit is emitted as {COL_ADDR, RowAddr, ToT} through a Valid/Ready FIFO
//  towards the column bus.
// PARAMETERS
//  COL_ADDR   6'd0  column address placed in the upper word bits
//  COL_W      6     width of COL_ADDR
//  FIFO_DEPTH 2     output FIFO entries, power of 2, >=2
// PORTS
//  Clk         in   1      core clock
//  ResetB      in   1      async active-low reset
//  Start       in   1      1-cycle pulse; begins a readout pass
//  HitPending  in   16     row r has stored hit data
//  Token       out  16     one-hot read grant (index 0..15), 0 when idle
//  RowAddr     out  4      binary index of Token
//  RdEn        out  1      read strobe; the granted row clears its pending flag
//  RdData      in   16     ToT data (4x4b) for the granted row, valid 1 cycle after RdEn
//  OutData     out  COL_W+20  {COL_ADDR,RowAddr,ToT}
//  OutValid    out  1      OutData valid
//  OutReady    in   1      downstream accepts the word when OutValid&OutReady
//  Busy        out  1      a pass is in progress
//  Done        out  1      1-cycle pulse at end of pass
// BEHAVIOUR
//  - Reset (async): state=IDLE; PendMask, Token, RowAddr, RdEn, OutValid, Busy and
//    Done are all 0; FIFO is empty; OutData is 0.
//  - FSM: IDLE -> SCAN -> DRAIN -> IDLE.
//  - IDLE: on Start, load PendMask<=HitPending and set Busy=1 at the next edge.
//    A zero snapshot still enters SCAN and ends without issuing any read.
//  - SCAN: each cycle where PendMask!=0 and (FifoCount+InFlight)<FIFO_DEPTH:
//    - Token=lowest set bit of PendMask, RowAddr=its index, RdEn=1 for that cycle;
//    - that bit is cleared from PendMask.
//    Otherwise Token=0 and RdEn=0. When PendMask==0, go to DRAIN.
//  - Capture: InFlight=1 on the cycle after RdEn. RdData is written to the FIFO
//    together with the RowAddr registered at RdEn.
//  - Throughput: one read per cycle while OutReady=1. There is at most one read in
//    flight, so the FIFO never overflows.
//  - DRAIN: wait until InFlight=0, then pulse Done=1 for 1 cycle, drop Busy and go
//    to IDLE. Done does not wait for the FIFO to empty.
//  - Latency: Start@c0 -> RdEn@c1 -> FIFO write@c2 -> OutValid=1@c3 (registered output).
//  - FIFO: first-word-fall-through, wrap-around pointers. OutData/OutValid stay
//    stable while OutReady=0. A write and a read in the same cycle leave FifoCount
//    unchanged.
//  - Start while Busy is ignored. HitPending changes after the snapshot are not
//    seen until the next pass.
//  - Token is never multi-hot. This is required by the downstream wired-NAND
//    address encoder.
//  - Reset during a pass aborts it: the FIFO contents are discarded and no Done
//    pulse is issued.
// CONFIGURATION
//  ROW_READOUT_EOC_TRAILER_EN: when defined, DRAIN also pushes one trailer word
//  {COL_ADDR, 4'hF, 16'hFFFF} into the FIFO after the last hit, including passes
//  with a zero snapshot.
//  - Done is issued on the cycle the trailer is written, and only when the FIFO has
//    a free slot.
//  - When undefined, no trailer is produced and Done follows the InFlight=0 rule
//    above.
// STRUCTURE
//  - Shared package rd53_core_pkg: ROW_N=16, ROW_W=4, TOT_W=16, the EOC trailer
//    constant and the FSM state enum.
//  - One sub-module: row_readout_fifo (FWFT, parameter FIFO_DEPTH, count output).
//  - The lowest-set-bit select and the one-hot-to-binary encode are local
//    combinational logic.
// TESTING
//  1. HitPending=16'h8421, Start, OutReady=1 -> RdEn@c1..c4 with
//     RowAddr=0,5,10,15; 4 words; Done@c6.
//  2. HitPending=0, Start -> no RdEn, no OutValid; Done 2 cycles after Start.
//     With the macro: one trailer word.
//  3. HitPending=16'hFFFF, OutReady held 0 -> exactly FIFO_DEPTH reads, then stall
//     with OutData stable. Release OutReady -> all 16 rows delivered in order, no
//     loss.
//  4. Toggle OutReady randomly during 16'hFFFF -> Token is always one-hot; 16
//     words, rows ascending, each ToT matches the model.
//  5. Start pulsed again mid-pass and HitPending changed -> ignored; only rows in
//     the snapshot are read.
//  6. ResetB low mid-pass -> all outputs 0 immediately. A new Start after reset
//     reads the current HitPending.

Source files
------------

// File: rtl/rd53_core_pkg.sv
// Shared core-column definitions: row geometry, ToT width, EOC trailer and readout FSM states.
package rd53_core_pkg;

  localparam int ROW_N = 16;
  localparam int ROW_W = 4;
  localparam int TOT_W = 16;

  localparam logic [ROW_W-1:0] EOC_ROW = 4'hF;
  localparam logic [TOT_W-1:0] EOC_TOT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/row_token_readout_if.sv
// Row-readout bus: pass control, row grant/read port and column-bus output handshake.
interface row_token_readout_if #(
  parameter int COL_W = 6
);
  import rd53_core_pkg::*;

  logic                           Start;
  logic [ROW_N-1:0]               HitPending;
  logic [ROW_N-1:0]               Token;
  logic [ROW_W-1:0]               RowAddr;
  logic                           RdEn;
  logic [TOT_W-1:0]               RdData;
  logic [COL_W+ROW_W+TOT_W-1:0]   OutData;
  logic                           OutValid;
  logic                           OutReady;
  logic                           Busy;
  logic                           Done;

  modport slave (
    input  Start, HitPending, RdData, OutReady,
    output Token, RowAddr, RdEn, OutData, OutValid, Busy, Done
  );

  modport master (
    output Start, HitPending, RdData, OutReady,
    input  Token, RowAddr, RdEn, OutData, OutValid, Busy, Done
  );

endinterface

// File: rtl/row_readout_fifo.sv
// First-word-fall-through output FIFO with wrap-around pointers and an occupancy count.
module row_readout_fifo #(
  parameter  int WIDTH = 26,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             ResetB,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_wr_en && (r_count != CNT_W'(DEPTH));
  assign w_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;

endmodule

// File: rtl/row_token_readout.sv
// Core-column readout sequencer: snapshots HitPending on Start, grants rows lowest-first
// with a one-hot token and queues {COL_ADDR, RowAddr, ToT}. Option: ROW_READOUT_EOC_TRAILER_EN.
//
// state | meaning
// IDLE  | waiting for Start
// SCAN  | granting snapshot rows one per cycle while the FIFO has room
// DRAIN | waiting for the last read data (and a trailer slot), then Done
module row_token_readout
  import rd53_core_pkg::*;
#(
  parameter int               COL_W      = 6,
  parameter logic [COL_W-1:0] COL_ADDR   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input logic                Clk,
  input logic                ResetB,
  row_token_readout_if.slave bus
);

  localparam int WORD_W = COL_W + ROW_W + TOT_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROW_N-1:0]   r_pend;
  logic [ROW_N-1:0]   w_lowest;
  logic [ROW_N-1:0]   w_token;
  logic [ROW_W-1:0]   r_rd_row;
  logic [ROW_W-1:0]   w_row_addr;
  logic               r_inflight;
  logic               w_rd_en;
  logic               w_done;
  logic               w_trl_wr;
  logic               w_pop;
  logic               w_room;
  logic               w_fifo_wr;
  logic               w_fifo_valid;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic [CNT_W:0]     w_occ;
  logic [CNT_W:0]     w_lim;
  logic [WORD_W-1:0]  w_wr_word;
  logic [WORD_W-1:0]  w_fifo_data;

  assign w_pop    = w_fifo_valid & bus.OutReady;
  assign w_lowest = r_pend & (~r_pend + 1'b1);

  // A word leaving the FIFO this cycle frees a slot in time for the next capture,
  // which keeps back-to-back reads going with only two entries.
  assign w_occ  = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, r_inflight};
  assign w_lim  = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};
  assign w_room = (w_occ < w_lim);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    w_trl_wr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_pend == '0)  w_state_nxt = ST_DRAIN;
        else if (w_room)   w_rd_en     = 1'b1;
      end
      ST_DRAIN: begin
`ifdef ROW_READOUT_EOC_TRAILER_EN
        if (!r_inflight && (w_fifo_cnt < CNT_W'(FIFO_DEPTH))) begin
          w_trl_wr    = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`else
        if (!r_inflight) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_token = w_rd_en ? w_lowest : '0;

  always_comb begin
    w_row_addr = '0;
    for (int i = 0; i < ROW_N; i++) begin
      if (w_token[i]) w_row_addr = w_row_addr | ROW_W'(i);
    end
  end

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_inflight <= 1'b0;
      r_rd_row   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_rd_row <= w_row_addr;
        r_pend   <= r_pend & ~w_token;
      end else if ((r_state == ST_IDLE) && bus.Start) begin
        r_pend <= bus.HitPending;
      end
    end
  end

  // The trailer only ever goes in from DRAIN with nothing in flight, so the mux never collides.
  assign w_fifo_wr = r_inflight | w_trl_wr;
  assign w_wr_word = r_inflight ? {COL_ADDR, r_rd_row, bus.RdData}
                                : {COL_ADDR, EOC_ROW, EOC_TOT};

  row_readout_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .ResetB    (ResetB),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_valid   (w_fifo_valid),
    .o_count   (w_fifo_cnt)
  );

  assign bus.Token    = w_token;
  assign bus.RowAddr  = w_row_addr;
  assign bus.RdEn     = w_rd_en;
  assign bus.OutData  = w_fifo_data;
  assign bus.OutValid = w_fifo_valid;
  assign bus.Busy     = (r_state != ST_IDLE);
  assign bus.Done     = w_done;

endmodule

// File: tb/tb_row_token_readout.sv
// Bench for row_token_readout: table of passes plus stall, re-Start and reset sequences,
// with row-order and output-word scoreboards.
module tb_row_token_readout;
  import rd53_core_pkg::*;

  localparam int               COL_W      = 6;
  localparam logic [COL_W-1:0] COL_ADDR   = 6'd0;
  localparam int               FIFO_DEPTH = 2;
  localparam int               WORD_W     = COL_W + ROW_W + TOT_W;

  typedef struct {
    logic [15:0] hp;
    logic [7:0]  salt;
    int          mode;      // 0: OutReady held 1, 1: random OutReady
    int          exp_reads;
    int          exp_done;  // Done latency from Start, -1 = not checked
  } vec_t;

  logic Clk = 1'b0;
  logic ResetB = 1'b0;
  always #5 Clk = ~Clk;

  row_token_readout_if #(.COL_W(COL_W)) bus();

  row_token_readout #(
    .COL_W      (COL_W),
    .COL_ADDR   (COL_ADDR),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Clk    (Clk),
    .ResetB (ResetB),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, done_base, rden_cnt, first_rden, last_rden, done_cnt, done_cyc;
  logic [7:0]        salt = 8'h00;
  int                exp_rows[$];
  logic [WORD_W-1:0] exp_words[$];
  vec_t              vecs[8];

  function automatic logic [15:0] tot_of(input int row, input logic [7:0] s);
    return {s, 4'(row), ~4'(row)};
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input int row, input logic [7:0] s);
    return {COL_ADDR, 4'(row), tot_of(row, s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Pixel array model: ToT data appears the cycle after the row is granted.
  always @(posedge Clk) bus.RdData <= bus.RdEn ? tot_of(int'(bus.RowAddr), salt) : 16'h0;

  initial begin
    done_cnt = 0; done_cyc = 0; rden_cnt = 0; first_rden = -1; last_rden = -1;
  end

  always @(negedge Clk) begin
    if (ResetB) begin
      if (bus.RdEn) begin
        chk("read_expected", exp_rows.size() != 0, 1);
        if (exp_rows.size() != 0) begin
          int r;
          r = exp_rows.pop_front();
          chk("row_addr", bus.RowAddr, r);
          chk("token_onehot", bus.Token, 16'h1 << r);
        end
        rden_cnt++;
        if (rden_cnt == 1) first_rden = cyc;
        last_rden = cyc;
      end else begin
        chk("token_idle", bus.Token, 0);
      end
      if (bus.OutValid && bus.OutReady) begin
        chk("word_expected", exp_words.size() != 0, 1);
        if (exp_words.size() != 0) chk("out_word", bus.OutData, exp_words.pop_front());
      end
      if (bus.Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_pass(input logic [15:0] hp, input logic [7:0] s);
    @(posedge Clk); #1;
    salt = s;
    bus.HitPending = hp;
    bus.Start = 1'b1;
    start_cyc = cyc;
    done_base = done_cnt;
    rden_cnt = 0; first_rden = -1; last_rden = -1;
    for (int i = 0; i < ROW_N; i++) begin
      if (hp[i]) begin
        exp_rows.push_back(i);
        exp_words.push_back(word_of(i, s));
      end
    end
`ifdef ROW_READOUT_EOC_TRAILER_EN
    exp_words.push_back({COL_ADDR, EOC_ROW, EOC_TOT});
`endif
    @(posedge Clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic finish_pass(input int mode, input int exp_reads, input int exp_done);
    int n;
    for (n = 0; n < 400; n++) begin
      if (done_cnt != done_base && exp_words.size() == 0 && !bus.OutValid) break;
      bus.OutReady = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
    end
    chk("pass_bound", n < 400, 1);
    chk("done_count", done_cnt - done_base, 1);
    chk("read_count", rden_cnt, exp_reads);
    chk("sb_empty", exp_rows.size() + exp_words.size(), 0);
    if (exp_done >= 0) begin
      chk("done_lat", done_cyc - start_cyc, exp_done);
      if (exp_reads > 0) begin
        chk("first_rden_lat", first_rden - start_cyc, 1);
        chk("last_rden_lat", last_rden - start_cyc, exp_reads);
      end
    end
  endtask

  initial begin
    int saved_done;
    bus.Start = 1'b0;
    bus.HitPending = '0;
    bus.OutReady = 1'b0;

    vecs[0] = '{16'h8421, 8'h11, 0, 4, 6};
    vecs[1] = '{16'h0000, 8'h22, 0, 0, 2};
    vecs[2] = '{16'h0001, 8'h23, 0, 1, 3};
    vecs[3] = '{16'h8000, 8'h24, 0, 1, 3};
    vecs[4] = '{16'hFFFF, 8'h25, 0, 16, 18};
    vecs[5] = '{16'hFFFF, 8'h26, 1, 16, -1};
    vecs[6] = '{16'hA5A5, 8'h27, 1, 8, -1};
    vecs[7] = '{16'h0100, 8'h28, 1, 1, -1};

    #1;
    chk("rst_ctrl", {bus.Token, bus.RowAddr, bus.RdEn, bus.OutValid, bus.Busy, bus.Done}, 0);
    chk("rst_data", bus.OutData, 0);
    repeat (2) @(posedge Clk);
    #2 ResetB = 1'b1;

    for (int v = 0; v < 8; v++) begin
      bus.OutReady = (vecs[v].mode == 0);
      start_pass(vecs[v].hp, vecs[v].salt);
      finish_pass(vecs[v].mode, vecs[v].exp_reads, vecs[v].exp_done);
    end

    // Back-pressure: FIFO fills after exactly FIFO_DEPTH reads and holds its head word.
    bus.OutReady = 1'b0;
    start_pass(16'hFFFF, 8'h33);
    repeat (6) @(posedge Clk);
    #1;
    chk("stall_reads", rden_cnt, FIFO_DEPTH);
    chk("stall_valid", bus.OutValid, 1);
    chk("stall_data", bus.OutData, word_of(0, 8'h33));
    repeat (3) @(posedge Clk);
    #1;
    chk("stall_hold", bus.OutData, word_of(0, 8'h33));
    chk("stall_reads_hold", rden_cnt, FIFO_DEPTH);
    chk("stall_busy", bus.Busy, 1);
    finish_pass(0, 16, -1);

    // Start and HitPending changes mid-pass are ignored.
    bus.OutReady = 1'b1;
    start_pass(16'h00F0, 8'h55);
    bus.Start = 1'b1;
    bus.HitPending = 16'hFF0F;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    finish_pass(0, 4, 6);

    // Reset mid-pass aborts it with no Done; the next pass snapshots fresh flags.
    bus.OutReady = 1'b0;
    start_pass(16'hFFFF, 8'h66);
    repeat (3) @(posedge Clk);
    #3;
    saved_done = done_cnt;
    ResetB = 1'b0;
    #1;
    chk("abort_ctrl", {bus.Token, bus.RowAddr, bus.RdEn, bus.OutValid, bus.Busy, bus.Done}, 0);
    chk("abort_data", bus.OutData, 0);
    exp_rows.delete();
    exp_words.delete();
    @(posedge Clk);
    #3 ResetB = 1'b1;
    repeat (2) @(posedge Clk);
    chk("abort_no_done", done_cnt, saved_done);
    bus.OutReady = 1'b1;
    start_pass(16'h0003, 8'h77);
    finish_pass(0, 2, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
